// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg : shared encodings for the dmem load/store initiator and lane logic
// Revision : 1.0
// ============================================================================
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [1:0] MEM_EN_IDLE = 2'b00;
    localparam logic [1:0] MEM_EN_RD   = 2'b01;
    localparam logic [1:0] MEM_EN_WR   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } dmem_state_e;

    // Halves must sit on an even byte, words on a word boundary; size 11 never legal.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = off[0];
            SZ_WORD: err = |off;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane.sv
`default_nettype none
// ============================================================================
// dmem_lane : byte-lane steering for a 32-bit memory port (alignment check,
//             write mask, store replication, load extract and extend)
// Revision  : 1.0
// ============================================================================
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic        err_o,
    output logic [3:0]  we_o,
    output logic [31:0] din_o,
    output logic [31:0] rdata_o
);

    logic [31:0] w_shifted;
    logic        w_sign;

    always_comb begin
        err_o     = access_err(size_i, off_i);
        we_o      = 4'b0000;
        din_o     = 32'h0000_0000;
        rdata_o   = 32'h0000_0000;
        w_sign    = 1'b0;
        // Addressed lane moved down to bit 0 so extraction is size-only.
        w_shifted = rdata_i >> {off_i, 3'b000};
        case (size_i)
            SZ_BYTE: begin
                we_o    = 4'b0001 << off_i;
                din_o   = {4{wdata_i[7:0]}};
                w_sign  = ~unsigned_i & w_shifted[7];
                rdata_o = {{24{w_sign}}, w_shifted[7:0]};
            end
            SZ_HALF: begin
                we_o    = 4'b0011 << off_i;
                din_o   = {2{wdata_i[15:0]}};
                w_sign  = ~unsigned_i & w_shifted[15];
                rdata_o = {{16{w_sign}}, w_shifted[15:0]};
            end
            SZ_WORD: begin
                we_o    = 4'b1111;
                din_o   = wdata_i;
                rdata_o = rdata_i;
            end
            default: begin
                we_o    = 4'b0000;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_master.sv
`default_nettype none
// ============================================================================
// dmem_master : single-outstanding load/store initiator for the dmem port
// Revision    : 1.0
// ============================================================================
module dmem_master
    import dmem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [1:0]  mem_en_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_din_o,
    input  logic [31:0] mem_dout_i
);

    localparam logic [1:0] c_wait_init = 2'(RD_LAT - 1);

    dmem_state_e state_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [1:0]  mem_en_q;
    logic [3:0]  mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_din_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        unsigned_q;
    logic [1:0]  wait_cnt_q;

    logic        w_accept;
    logic [1:0]  w_lane_size;
    logic [1:0]  w_lane_off;
    logic        w_lane_err;
    logic [3:0]  w_lane_we;
    logic [31:0] w_lane_din;
    logic [31:0] w_lane_rdata;

    assign w_accept = req_valid_i & req_ready_q;

    // In IDLE the lane decodes the incoming request; afterwards the latched one.
    assign w_lane_size = (state_q == ST_IDLE) ? req_size_i      : size_q;
    assign w_lane_off  = (state_q == ST_IDLE) ? req_addr_i[1:0] : off_q;

    dmem_lane u_lane (
        .size_i     (w_lane_size),
        .off_i      (w_lane_off),
        .unsigned_i (unsigned_q),
        .wdata_i    (req_wdata_i),
        .rdata_i    (mem_dout_i),
        .err_o      (w_lane_err),
        .we_o       (w_lane_we),
        .din_o      (w_lane_din),
        .rdata_o    (w_lane_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            mem_en_q    <= MEM_EN_IDLE;
            mem_we_q    <= 4'b0000;
            mem_addr_q  <= 32'h0000_0000;
            mem_din_q   <= 32'h0000_0000;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            off_q       <= 2'b00;
            unsigned_q  <= 1'b0;
            wait_cnt_q  <= 2'b00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (w_accept) begin
                        req_ready_q <= 1'b0;
                        we_q        <= req_we_i;
                        size_q      <= req_size_i;
                        off_q       <= req_addr_i[1:0];
                        unsigned_q  <= req_unsigned_i;
                        if (w_lane_err) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0000_0000;
                        end else begin
                            state_q    <= ST_ISSUE;
                            mem_addr_q <= {req_addr_i[31:2], 2'b00};
                            if (req_we_i) begin
                                mem_en_q  <= MEM_EN_WR;
                                mem_we_q  <= w_lane_we;
                                mem_din_q <= w_lane_din;
                            end else begin
                                mem_en_q  <= MEM_EN_RD;
                                mem_we_q  <= 4'b0000;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    mem_en_q <= MEM_EN_IDLE;
                    mem_we_q <= 4'b0000;
                    if (we_q) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= 32'h0000_0000;
                    end else begin
                        state_q    <= ST_WAIT;
                        wait_cnt_q <= c_wait_init;
                    end
                end
                ST_WAIT: begin
                    // WAIT spans the RD_LAT cycles after ISSUE; the last one carries mem_dout.
                    if (wait_cnt_q == 2'b00) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= w_lane_rdata;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 2'b01;
                    end
                end
                ST_RESP: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_din_o   = mem_din_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_dmem_master : scoreboard bench for dmem_master at RD_LAT=3 and RD_LAT=1
// Revision       : 1.0
// ============================================================================
module tb_dmem_master;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        rdy3, rv3, err3, rdy1, rv1, err1;
    logic [31:0] rd3, maddr3, mdin3, mdout3, rd1, maddr1, mdin1, mdout1;
    logic [1:0]  men3, men1;
    logic [3:0]  mwe3, mwe1;

    always #5 clk = ~clk;

    dmem_master #(.RD_LAT(3)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(rdy3), .req_we_i(req_we),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rv3), .rsp_rdata_o(rd3), .rsp_err_o(err3),
        .mem_en_o(men3), .mem_we_o(mwe3), .mem_addr_o(maddr3),
        .mem_din_o(mdin3), .mem_dout_i(mdout3)
    );

    dmem_master #(.RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(rdy1), .req_we_i(req_we),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rv1), .rsp_rdata_o(rd1), .rsp_err_o(err1),
        .mem_en_o(men1), .mem_we_o(mwe1), .mem_addr_o(maddr1),
        .mem_din_o(mdin1), .mem_dout_i(mdout1)
    );

    // Memory model: read data is valid only in the single cycle RD_LAT after the read strobe.
    logic [31:0] rd_word = 32'h0;
    logic [3:0]  pipe3 = 4'b0;
    logic [3:0]  pipe1 = 4'b0;
    always @(posedge clk) begin
        pipe3 <= {pipe3[2:0], men3 == MEM_EN_RD};
        pipe1 <= {pipe1[2:0], men1 == MEM_EN_RD};
    end
    assign mdout3 = pipe3[2] ? rd_word : 32'hDEAD_BEEF;
    assign mdout1 = pipe1[0] ? rd_word : 32'hDEAD_BEEF;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rsp_cnt3 = 0;
    int men_cnt3 = 0;
    always begin
        @(negedge clk);
        #2;
        if (rv3 === 1'b1) rsp_cnt3 = rsp_cnt3 + 1;
        if (men3 !== 2'b00) men_cnt3 = men_cnt3 + 1;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t sb1[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input bit hold, output int t);
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        t = -1;
        for (int i = 0; i < 20; i++) begin
            if (rdy3 && rdy1) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        if (t < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL send_ready: req_ready got 0, need 1 within 20 cycles");
            req_valid = 1'b0;
        end else begin
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(input bit one, output logic [31:0] rd, output logic e, output int c);
        c = -1; rd = '0; e = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (one ? rv1 : rv3) begin
                c  = cyc;
                rd = one ? rd1 : rd3;
                e  = one ? err1 : err3;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rdy3, rv3, err3, men3, mwe3} !== 9'b0 || rd3 !== 32'h0 || maddr3 !== 32'h0 || mdin3 !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b err=%b en=%b we=%b rd=%h addr=%h din=%h, need all 0",
                     rdy3, rv3, err3, men3, mwe3, rd3, maddr3, mdin3);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (rdy3 !== 1'b0) begin
            n_bad++; $display("FAIL reset_ready_before_edge: got %b need 0", rdy3);
        end
        @(negedge clk);
        n_cmp++;
        if (rdy3 !== 1'b1 || rdy1 !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready_after_edge: got %b/%b need 1/1", rdy3, rdy1);
        end
    endtask

    logic [1:0]  st_sz   [5] = '{SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BYTE, SZ_HALF};
    logic [31:0] st_addr [5] = '{32'h80000001, 32'h80000002, 32'h80000000, 32'h80000003, 32'h80000000};
    logic [3:0]  st_we   [5] = '{4'b0010, 4'b1100, 4'b1111, 4'b1000, 4'b0011};
    logic [31:0] st_din  [5] = '{32'h18181818, 32'h11181118, 32'h20221118, 32'h18181818, 32'h11181118};

    task automatic test_store();
        int t, c; logic [31:0] rd; logic e; exp_t ex;
        for (int k = 0; k < 5; k++) begin
            send(1'b1, st_sz[k], 1'b0, st_addr[k], 32'h20221118, 1'b0, t);
            sb.push_back('{rdata: 32'h0, err: 1'b0, cyc: t + 2});
            n_cmp++;
            if (men3 !== MEM_EN_WR || mwe3 !== st_we[k] || maddr3 !== 32'h80000000 || mdin3 !== st_din[k]) begin
                n_bad++;
                $display("FAIL store_issue[%0d]: got en=%b we=%b addr=%h din=%h, need en=10 we=%b addr=80000000 din=%h",
                         k, men3, mwe3, maddr3, mdin3, st_we[k], st_din[k]);
            end
            @(negedge clk);
            n_cmp++;
            if (men3 !== MEM_EN_IDLE || mwe3 !== 4'b0) begin
                n_bad++; $display("FAIL store_after_issue[%0d]: got en=%b we=%b need 00/0000", k, men3, mwe3);
            end
            wait_rsp(1'b0, rd, e, c);
            ex = sb.pop_front();
            n_cmp++;
            if (rd !== ex.rdata || e !== ex.err || c != ex.cyc) begin
                n_bad++;
                $display("FAIL store_rsp[%0d]: got rdata=%h err=%b cyc=%0d, need rdata=%h err=%b cyc=%0d",
                         k, rd, e, c, ex.rdata, ex.err, ex.cyc);
            end
        end
    endtask

    task automatic test_load_word();
        int t, c; logic [31:0] rd; logic e; exp_t ex;
        rd_word = 32'h18790475;
        send(1'b0, SZ_WORD, 1'b0, 32'h00100004, 32'h0, 1'b0, t);
        sb.push_back('{rdata: 32'h18790475, err: 1'b0, cyc: t + 5});
        sb1.push_back('{rdata: 32'h18790475, err: 1'b0, cyc: t + 3});
        n_cmp++;
        if (men3 !== MEM_EN_RD || men1 !== MEM_EN_RD || mwe3 !== 4'b0 || maddr3 !== 32'h00100004) begin
            n_bad++;
            $display("FAIL load_issue: got en3=%b en1=%b we=%b addr=%h, need 01/01/0000/00100004", men3, men1, mwe3, maddr3);
        end
        @(negedge clk);
        n_cmp++;
        if (men3 !== MEM_EN_IDLE || men1 !== MEM_EN_IDLE) begin
            n_bad++; $display("FAIL load_en_one_cycle: got en3=%b en1=%b need 00/00", men3, men1);
        end
        wait_rsp(1'b1, rd, e, c);
        ex = sb1.pop_front();
        n_cmp++;
        if (rd !== ex.rdata || e !== ex.err || c != ex.cyc) begin
            n_bad++;
            $display("FAIL load_word_lat1: got rdata=%h err=%b cyc=%0d, need rdata=%h err=%b cyc=%0d",
                     rd, e, c, ex.rdata, ex.err, ex.cyc);
        end
        wait_rsp(1'b0, rd, e, c);
        ex = sb.pop_front();
        n_cmp++;
        if (rd !== ex.rdata || e !== ex.err || c != ex.cyc) begin
            n_bad++;
            $display("FAIL load_word_lat3: got rdata=%h err=%b cyc=%0d, need rdata=%h err=%b cyc=%0d",
                     rd, e, c, ex.rdata, ex.err, ex.cyc);
        end
    endtask

    logic [1:0]  ld_sz   [5] = '{SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF, SZ_HALF};
    logic        ld_uns  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] ld_addr [5] = '{32'h00100003, 32'h00100003, 32'h00100000, 32'h00100002, 32'h00100002};
    logic [31:0] ld_exp  [5] = '{32'hFFFFFFA5, 32'h000000A5, 32'h00007233, 32'hFFFFA525, 32'h0000A525};

    task automatic test_load_extend();
        int t, c; logic [31:0] rd; logic e; exp_t ex;
        rd_word = 32'hA5257233;
        for (int k = 0; k < 5; k++) begin
            send(1'b0, ld_sz[k], ld_uns[k], ld_addr[k], 32'h0, 1'b0, t);
            sb.push_back('{rdata: ld_exp[k], err: 1'b0, cyc: t + 5});
            wait_rsp(1'b0, rd, e, c);
            ex = sb.pop_front();
            n_cmp++;
            if (rd !== ex.rdata || e !== ex.err || c != ex.cyc) begin
                n_bad++;
                $display("FAIL load_extend[%0d]: got rdata=%h err=%b cyc=%0d, need rdata=%h err=%b cyc=%0d",
                         k, rd, e, c, ex.rdata, ex.err, ex.cyc);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (rv3 !== 1'b0 || rd3 !== 32'h0000A525) begin
            n_bad++; $display("FAIL rsp_hold: got rv=%b rdata=%h, need 0/0000a525", rv3, rd3);
        end
    endtask

    logic [1:0]  er_sz   [3] = '{SZ_HALF, SZ_ILL, SZ_WORD};
    logic [31:0] er_addr [3] = '{32'h80000001, 32'h80000000, 32'h80000002};

    task automatic test_errors();
        int t, c, cnt0, men0; logic [31:0] rd; logic e; exp_t ex;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cnt0 = rsp_cnt3; men0 = men_cnt3;
            send(1'b1, er_sz[k], 1'b0, er_addr[k], 32'h20221118, k == 0, t);
            sb.push_back('{rdata: 32'h0, err: 1'b1, cyc: t + 1});
            n_cmp++;
            if (rdy3 !== 1'b0) begin
                n_bad++; $display("FAIL err_busy[%0d]: got req_ready=%b need 0", k, rdy3);
            end
            wait_rsp(1'b0, rd, e, c);
            ex = sb.pop_front();
            n_cmp++;
            if (rd !== ex.rdata || e !== ex.err || c != ex.cyc) begin
                n_bad++;
                $display("FAIL err_rsp[%0d]: got rdata=%h err=%b cyc=%0d, need rdata=%h err=%b cyc=%0d",
                         k, rd, e, c, ex.rdata, ex.err, ex.cyc);
            end
            @(negedge clk);
            req_valid = 1'b0;
            repeat (3) @(negedge clk);
            n_cmp++;
            if (rsp_cnt3 != cnt0 + 1 || men_cnt3 != men0) begin
                n_bad++;
                $display("FAIL err_single[%0d]: got rsp=%0d mem_act=%0d, need rsp=1 mem_act=0",
                         k, rsp_cnt3 - cnt0, men_cnt3 - men0);
            end
        end
    endtask

    task automatic test_reset_midop();
        int t, cnt0;
        rd_word = 32'h18790475;
        send(1'b0, SZ_WORD, 1'b0, 32'h00100004, 32'h0, 1'b0, t);
        @(negedge clk);
        cnt0 = rsp_cnt3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (men3 !== 2'b00 || mwe3 !== 4'b0 || rdy3 !== 1'b0 || rv3 !== 1'b0 || maddr3 !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_midop: got en=%b we=%b rdy=%b rv=%b addr=%h, need all 0", men3, mwe3, rdy3, rv3, maddr3);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rdy3 !== 1'b1) begin
            n_bad++; $display("FAIL reset_midop_ready: got %b need 1", rdy3);
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (rsp_cnt3 != cnt0) begin
            n_bad++; $display("FAIL reset_midop_drop: got %0d rsp pulses need 0", rsp_cnt3 - cnt0);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, c; logic [31:0] rd; logic e; exp_t ex;
        send(1'b1, SZ_WORD, 1'b0, 32'h80000000, 32'h12345678, 1'b0, t1);
        sb.push_back('{rdata: 32'h0, err: 1'b0, cyc: t1 + 2});
        wait_rsp(1'b0, rd, e, c);
        ex = sb.pop_front();
        n_cmp++;
        if (rd !== ex.rdata || e !== ex.err || c != ex.cyc) begin
            n_bad++;
            $display("FAIL b2b_rsp0: got rdata=%h err=%b cyc=%0d, need rdata=%h err=%b cyc=%0d",
                     rd, e, c, ex.rdata, ex.err, ex.cyc);
        end
        send(1'b1, SZ_BYTE, 1'b0, 32'h80000002, 32'h000000C3, 1'b0, t2);
        sb.push_back('{rdata: 32'h0, err: 1'b0, cyc: t2 + 2});
        n_cmp++;
        if (t2 != t1 + 3 || mwe3 !== 4'b0100 || mdin3 !== 32'hC3C3C3C3) begin
            n_bad++;
            $display("FAIL b2b_accept: got gap=%0d we=%b din=%h, need gap=3 we=0100 din=c3c3c3c3",
                     t2 - t1, mwe3, mdin3);
        end
        wait_rsp(1'b0, rd, e, c);
        ex = sb.pop_front();
        n_cmp++;
        if (rd !== ex.rdata || e !== ex.err || c != ex.cyc) begin
            n_bad++;
            $display("FAIL b2b_rsp1: got rdata=%h err=%b cyc=%0d, need rdata=%h err=%b cyc=%0d",
                     rd, e, c, ex.rdata, ex.err, ex.cyc);
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_word();
        test_load_extend();
        test_errors();
        test_reset_midop();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
